shadow_chain_rx: RTL and testbench
==================================

# shadow_chain_rx

Receive end of the shadow-capture dump chain. It requests a dump from a single-chain shadow_capture instance, for example the one inside sparc_mul_dp that captures {acc_reg_shf2, acc_reg}. It deserializes the bitstream on ch_out/ch_out_vld/ch_out_done into WORD_W-bit words and buffers them in a show-ahead FIFO for a host/debug reader. It sits in the sh_clk domain next to the core's shadow chains.

## Interface
Parameters:
- FRAME_BITS, 137, expected chain length in bits per dump.
- WORD_W, 32, deserialized word width.
- DEPTH, 8, FIFO depth in words; power of 2, ≥2.

Ports:
- sh_clk  in  1  shadow/data clock; the only clock.
- sh_rst_l  in  1  asynchronous, active-low reset.
- start  in  1  dump request; accepted only in IDLE.
- dump_en  out  1  dump enable to shadow_capture.
- ch_in  in  1  serial chain data (from ch_out).
- ch_in_vld  in  1  ch_in valid this cycle (from ch_out_vld).
- ch_in_done  in  1  last bit / chain done (from ch_out_done).
- rd_en  in  1  pop the FIFO head.
- rd_data  out  WORD_W  FIFO head; valid when rd_empty=0.
- rd_empty  out  1  FIFO empty.
- rd_count  out  $clog2(DEPTH)+1  words held.
- busy  out  1  frame in progress (state ≠ IDLE).
- done  out  1  one-cycle pulse when the frame has been fully buffered.
- ovf  out  1  sticky; a word was dropped because the FIFO was full.
- len_err  out  1  sticky; bits received ≠ FRAME_BITS.

## Operation
- Reset values: dump_en=0, rd_data=0, rd_empty=1, rd_count=0, busy=0, done=0, ovf=0, len_err=0. State=IDLE; bit counter, shift register and FIFO pointers are cleared.
- States and transitions:
  - IDLE: on start, clear ovf, len_err and the bit counter, then go to RECV. If the FIFO is not empty, its contents are kept.
  - RECV: dump_en=1. Each cycle with ch_in_vld=1, ch_in is shifted in LSB-first, so bit k of the frame lands at word k/WORD_W, bit k%WORD_W. When WORD_W bits have accumulated, the word is pushed. On ch_in_done, go to FLUSH.
  - FLUSH: dump_en=0. If a partial word is held, it is zero-padded at the MSBs and pushed. Then done pulses and the state returns to IDLE.
- If ch_in_vld and ch_in_done are high in the same cycle, that bit belongs to the frame.
- Bits with index ≥ FRAME_BITS are discarded and set len_err.
- If ch_in_done arrives with fewer than FRAME_BITS bits, the partial word is flushed and len_err is set.
- A 137-bit frame with WORD_W=32 gives 5 words; word 4 holds 9 valid bits in [8:0] and [31:9]=0.
- FIFO behaviour:
  - A push when full with no pop in the same cycle drops the word and sets ovf.
  - A push and pop in the same cycle when full are both accepted; rd_count is unchanged.
  - rd_en while empty is ignored.
- start while busy is ignored.
- ch_in_vld/ch_in_done while in IDLE are ignored.
- Asserting sh_rst_l low mid-frame aborts immediately: all state, including the FIFO contents, returns to reset values and dump_en drops asynchronously.
- A word counter and a bit counter wrap only by reset or start; there is no other wrap-around path.

## Timing
- Interface outputs are registered. The exception is rd_data, which is driven from the FIFO head register/array.
- start sampled at edge N → busy=1 and dump_en=1 from N+1.
- Bit latency: the last bit of a word is sampled at edge M → word visible on rd_data and rd_count incremented after M+1. If the FIFO was empty, rd_empty falls after M+1.
- Done latency: ch_in_done sampled at edge D → FLUSH in cycle D+1, with dump_en=0. The padded push and the done pulse occur in that same cycle. busy=0 from D+2.
- Back-to-back frames: start may be accepted in the first IDLE cycle after done.
- Pop: rd_en sampled at edge R → next head word (or rd_empty=1) from R+1.
- Throughput: 1 bit per cycle, with no back-pressure on the chain. ovf is the only loss indicator.

## Test plan
- Reset: hold sh_rst_l=0 for 3 cycles, then release → all outputs at their reset values; rd_empty=1, rd_count=0, dump_en=0.
- Full frame (defaults): pulse start, then drive 137 bits LSB-first encoding words 0xDEADBEEF, 0x01234567, 0x89ABCDEF, 0xCAFEF00D, with the final 9 bits =0x1A5; done on the last bit. Expected: rd_count=5, rd_data pops in order with word 4 =0x000001A5, a single done pulse, ovf=0, len_err=0, dump_en high for exactly the RECV cycles.
- Short and long frames: done after 40 bits of 0xFF → words 0xFFFFFFFF and 0x000000FF, len_err=1. A 140-bit frame → 5 words, extra 3 bits dropped, len_err=1.
- Overflow and boundary: DEPTH=4 with no reads, full frame → rd_count=4, ovf=1, 5th word lost. Repeat with rd_en=1 on the cycle the 5th word arrives → ovf=0 and the 5th word is retained.
- Protocol edges: start held high during RECV is ignored. ch_in_vld gaps of 0–5 cycles between bits give identical words. ch_in_vld/ch_in_done pulses in IDLE leave rd_count=0.
- Reset mid-operation: assert sh_rst_l=0 after 70 bits → dump_en=0 immediately, FIFO empty. A new start followed by a full frame produces the correct 5 words.

Source files
------------

// File: rtl/shadow_chain_rx.sv
// Receive end of the shadow-capture dump chain: requests a dump, deserializes the
// LSB-first bitstream into WORD_W-bit words and buffers them in a show-ahead FIFO.
module shadow_chain_rx #(
    parameter int unsigned FRAME_BITS = 137,
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                   sh_clk,
    input  logic                   sh_rst_l,
    input  logic                   start,
    output logic                   dump_en,
    input  logic                   ch_in,
    input  logic                   ch_in_vld,
    input  logic                   ch_in_done,
    input  logic                   rd_en,
    output logic [WORD_W-1:0]      rd_data,
    output logic                   rd_empty,
    output logic [$clog2(DEPTH):0] rd_count,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf,
    output logic                   len_err
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned BCW = $clog2(FRAME_BITS + 1);
    localparam int unsigned FW  = $clog2(WORD_W);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH} state_t;

    state_t             r_state;
    logic               r_dump_en;
    logic               r_busy;
    logic               r_done;
    logic               r_len_err;
    logic [BCW-1:0]     r_bit_cnt;
    logic [FW-1:0]      r_fill;
    logic [WORD_W-1:0]  r_shift;
    logic               r_pw_vld;
    logic [WORD_W-1:0]  r_pw_data;

    logic [WORD_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_empty;
    logic               r_ovf;

    logic               w_bit_take;
    logic               w_bit_drop;
    logic               w_word_full;
    logic               w_has_partial;
    logic               w_short;
    logic [BCW-1:0]     w_total;
    logic [WORD_W-1:0]  w_shift_nxt;
    logic               w_start_acc;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic [CW-1:0]      w_count_nxt;

    // Bit acceptance: bits past the expected frame length are discarded
    always_comb begin
        w_start_acc   = (r_state == S_IDLE) && start;
        w_bit_take    = (r_state == S_RECV) && ch_in_vld && (r_bit_cnt <  BCW'(FRAME_BITS));
        w_bit_drop    = (r_state == S_RECV) && ch_in_vld && (r_bit_cnt >= BCW'(FRAME_BITS));
        w_word_full   = w_bit_take && (r_fill == FW'(WORD_W - 1));
        w_has_partial = (r_fill != '0) || w_bit_take;
        w_total       = r_bit_cnt + BCW'(w_bit_take);
        w_short       = (r_state == S_RECV) && ch_in_done && (w_total < BCW'(FRAME_BITS));
        w_shift_nxt   = r_shift;
        if (w_bit_take) begin
            w_shift_nxt[r_fill] = ch_in;
        end
    end

    // Frame FSM; completed words go through a one-cycle push stage
    always_ff @(posedge sh_clk or negedge sh_rst_l) begin
        if (!sh_rst_l) begin
            r_state   <= S_IDLE;
            r_dump_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_len_err <= 1'b0;
            r_bit_cnt <= '0;
            r_fill    <= '0;
            r_shift   <= '0;
            r_pw_vld  <= 1'b0;
            r_pw_data <= '0;
        end else begin
            r_done   <= 1'b0;
            r_pw_vld <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_RECV;
                        r_dump_en <= 1'b1;
                        r_busy    <= 1'b1;
                        r_len_err <= 1'b0;
                        r_bit_cnt <= '0;
                        r_fill    <= '0;
                        r_shift   <= '0;
                    end
                end
                S_RECV: begin
                    if (w_bit_take) begin
                        r_bit_cnt <= r_bit_cnt + BCW'(1);
                        if (w_word_full) begin
                            r_pw_vld  <= 1'b1;
                            r_pw_data <= w_shift_nxt;
                            r_shift   <= '0;
                            r_fill    <= '0;
                        end else begin
                            r_shift <= w_shift_nxt;
                            r_fill  <= r_fill + FW'(1);
                        end
                    end
                    if (w_bit_drop || w_short) begin
                        r_len_err <= 1'b1;
                    end
                    if (ch_in_done) begin
                        r_state   <= S_FLUSH;
                        r_dump_en <= 1'b0;
                        r_done    <= 1'b1;
                        // Unused upper bits of the shift register are already zero
                        if (!w_word_full && w_has_partial) begin
                            r_pw_vld  <= 1'b1;
                            r_pw_data <= w_shift_nxt;
                            r_shift   <= '0;
                            r_fill    <= '0;
                        end
                    end
                end
                S_FLUSH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Show-ahead FIFO; a push into a full FIFO survives only with a same-cycle pop
    always_comb begin
        w_full      = (r_count == CW'(DEPTH));
        w_pop       = rd_en && !r_empty;
        w_push      = r_pw_vld && (!w_full || w_pop);
        w_drop      = r_pw_vld && w_full && !w_pop;
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge sh_clk or negedge sh_rst_l) begin
        if (!sh_rst_l) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_pw_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            if (w_start_acc) begin
                r_ovf <= 1'b0;
            end else if (w_drop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign dump_en  = r_dump_en;
    assign busy     = r_busy;
    assign done     = r_done;
    assign len_err  = r_len_err;
    assign ovf      = r_ovf;
    assign rd_empty = r_empty;
    assign rd_count = r_count;
    assign rd_data  = r_mem[r_rd_ptr];

endmodule

// File: tb/tb_shadow_chain_rx.sv
// Directed bench for shadow_chain_rx: a DEPTH=8 and a DEPTH=4 instance share the
// chain inputs; expected words are queued from the frame bits and popped on reads.
module tb_shadow_chain_rx;
    logic        sh_clk = 1'b0;
    logic        rst_n;
    logic        start8, start4, rd8, rd4;
    logic        ch_in, vld, dn;

    logic        de8, de4, e8, e4, busy8, busy4, done8, done4, ovf8, ovf4, le8, le4;
    logic [31:0] d8, d4;
    logic [3:0]  c8;
    logic [2:0]  c4;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] q[$];

    logic [159:0] full_f, long_f, short_f;

    always #5 sh_clk = ~sh_clk;

    shadow_chain_rx #(.FRAME_BITS(137), .WORD_W(32), .DEPTH(8)) u8 (
        .sh_clk(sh_clk), .sh_rst_l(rst_n), .start(start8), .dump_en(de8),
        .ch_in(ch_in), .ch_in_vld(vld), .ch_in_done(dn), .rd_en(rd8),
        .rd_data(d8), .rd_empty(e8), .rd_count(c8), .busy(busy8),
        .done(done8), .ovf(ovf8), .len_err(le8)
    );

    shadow_chain_rx #(.FRAME_BITS(137), .WORD_W(32), .DEPTH(4)) u4 (
        .sh_clk(sh_clk), .sh_rst_l(rst_n), .start(start4), .dump_en(de4),
        .ch_in(ch_in), .ch_in_vld(vld), .ch_in_done(dn), .rd_en(rd4),
        .rd_data(d4), .rd_empty(e4), .rd_count(c4), .busy(busy4),
        .done(done4), .ovf(ovf4), .len_err(le4)
    );

    function automatic logic [31:0] o_data(input int u);  return (u == 4) ? d4 : d8; endfunction
    function automatic logic [31:0] o_cnt(input int u);   return (u == 4) ? 32'(c4) : 32'(c8); endfunction
    function automatic logic [31:0] o_empty(input int u); return (u == 4) ? 32'(e4) : 32'(e8); endfunction
    function automatic logic [31:0] o_de(input int u);    return (u == 4) ? 32'(de4) : 32'(de8); endfunction
    function automatic logic [31:0] o_busy(input int u);  return (u == 4) ? 32'(busy4) : 32'(busy8); endfunction
    function automatic logic [31:0] o_done(input int u);  return (u == 4) ? 32'(done4) : 32'(done8); endfunction
    function automatic logic [31:0] o_ovf(input int u);   return (u == 4) ? 32'(ovf4) : 32'(ovf8); endfunction
    function automatic logic [31:0] o_le(input int u);    return (u == 4) ? 32'(le4) : 32'(le8); endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge sh_clk);
        #1;
    endtask

    task automatic set_start(input int u, input logic v);
        if (u == 4) start4 = v; else start8 = v;
    endtask

    task automatic set_rd(input int u, input logic v);
        if (u == 4) rd4 = v; else rd8 = v;
    endtask

    // Reference deserializer: bit k -> word k/32 bit k%32, only the first 137 bits count
    task automatic expect_words(input logic [159:0] bits, input int n, input int limit);
        int nv, nw;
        logic [31:0] w;
        nv = (n < 137) ? n : 137;
        nw = (nv + 31) / 32;
        for (int wi = 0; wi < nw && wi < limit; wi++) begin
            w = '0;
            for (int b = 0; b < 32; b++) begin
                if (wi * 32 + b < nv) w[b] = bits[wi * 32 + b];
            end
            q.push_back(w);
        end
    endtask

    task automatic send_frame(input int u, input logic [159:0] bits, input int n,
                              input int gap_max, input int hold, input bit with_done,
                              input bit pop_flush);
        int en_cyc, exp_cyc, g;
        en_cyc  = 0;
        exp_cyc = 0;
        set_start(u, 1'b1);
        tick;
        set_start(u, 1'b0);
        chk("busy_after_start", o_busy(u), 32'd1);
        chk("dump_en_after_start", o_de(u), 32'd1);
        for (int i = 0; i < n; i++) begin
            set_start(u, (i < hold));
            ch_in = bits[i];
            vld   = 1'b1;
            dn    = with_done && (i == n - 1);
            if (o_de(u) == 32'd1) en_cyc++;
            exp_cyc++;
            tick;
            vld = 1'b0; dn = 1'b0; ch_in = 1'b0;
            if (i != n - 1) begin
                g = int'($urandom_range(gap_max, 0));
                for (int j = 0; j < g; j++) begin
                    if (o_de(u) == 32'd1) en_cyc++;
                    exp_cyc++;
                    tick;
                end
            end
        end
        set_start(u, 1'b0);
        if (with_done) begin
            chk("dump_en_recv_cycles", 32'(en_cyc), 32'(exp_cyc));
            chk("done_pulse", o_done(u), 32'd1);
            chk("dump_en_flush", o_de(u), 32'd0);
            chk("busy_flush", o_busy(u), 32'd1);
            if (pop_flush) begin
                chk("pop_at_flush_data", o_data(u), q.pop_front());
                set_rd(u, 1'b1);
            end
            tick;
            set_rd(u, 1'b0);
            chk("done_cleared", o_done(u), 32'd0);
            chk("busy_idle", o_busy(u), 32'd0);
        end
    endtask

    task automatic drain(input int u);
        while (q.size() > 0) begin
            chk("rd_empty_before_pop", o_empty(u), 32'd0);
            chk("rd_data", o_data(u), q.pop_front());
            set_rd(u, 1'b1);
            tick;
            set_rd(u, 1'b0);
        end
        chk("rd_empty_after_drain", o_empty(u), 32'd1);
        chk("rd_count_after_drain", o_cnt(u), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0; rd8 = 1'b0; rd4 = 1'b0;
        ch_in = 1'b0; vld = 1'b0; dn = 1'b0;
        full_f  = {23'd0, 9'h1A5, 32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF};
        long_f  = full_f | (160'h7 << 137);
        short_f = {120'd0, 40'hFF_FFFF_FFFF};

        // Reset
        repeat (3) tick;
        rst_n = 1'b1;
        tick;
        chk("rst_dump_en", o_de(8), 32'd0);
        chk("rst_rd_data", o_data(8), 32'd0);
        chk("rst_rd_empty", o_empty(8), 32'd1);
        chk("rst_rd_count", o_cnt(8), 32'd0);
        chk("rst_busy", o_busy(8), 32'd0);
        chk("rst_done", o_done(8), 32'd0);
        chk("rst_ovf", o_ovf(8), 32'd0);
        chk("rst_len_err", o_le(8), 32'd0);
        chk("rst_rd_empty_d4", o_empty(4), 32'd1);

        // Full 137-bit frame
        expect_words(full_f, 137, 8);
        send_frame(8, full_f, 137, 0, 0, 1'b1, 1'b0);
        chk("full_count", o_cnt(8), 32'd5);
        chk("full_ovf", o_ovf(8), 32'd0);
        chk("full_len_err", o_le(8), 32'd0);
        drain(8);

        // Short frame: 40 ones
        expect_words(short_f, 40, 8);
        send_frame(8, short_f, 40, 0, 0, 1'b1, 1'b0);
        chk("short_count", o_cnt(8), 32'd2);
        chk("short_len_err", o_le(8), 32'd1);
        drain(8);

        // Long frame: 140 bits, last 3 dropped
        expect_words(long_f, 140, 8);
        send_frame(8, long_f, 140, 0, 0, 1'b1, 1'b0);
        chk("long_count", o_cnt(8), 32'd5);
        chk("long_len_err", o_le(8), 32'd1);
        chk("long_ovf", o_ovf(8), 32'd0);
        drain(8);

        // Random valid gaps of 0..5 cycles
        expect_words(full_f, 137, 8);
        send_frame(8, full_f, 137, 5, 0, 1'b1, 1'b0);
        chk("gap_count", o_cnt(8), 32'd5);
        chk("gap_len_err", o_le(8), 32'd0);
        drain(8);

        // start held high during the first 20 bits
        expect_words(full_f, 137, 8);
        send_frame(8, full_f, 137, 0, 20, 1'b1, 1'b0);
        chk("hold_count", o_cnt(8), 32'd5);
        drain(8);

        // Chain activity while idle
        for (int i = 0; i < 4; i++) begin
            ch_in = 1'b1; vld = 1'b1; dn = (i == 3);
            tick;
        end
        ch_in = 1'b0; vld = 1'b0; dn = 1'b0;
        tick;
        chk("idle_count", o_cnt(8), 32'd0);
        chk("idle_busy", o_busy(8), 32'd0);
        chk("idle_dump_en", o_de(8), 32'd0);

        // DEPTH=4, no reads: fifth word lost
        expect_words(full_f, 137, 4);
        send_frame(4, full_f, 137, 0, 0, 1'b1, 1'b0);
        chk("ovf_count", o_cnt(4), 32'd4);
        chk("ovf_set", o_ovf(4), 32'd1);
        chk("ovf_len_err", o_le(4), 32'd0);
        drain(4);

        // DEPTH=4, pop on the cycle the fifth word arrives
        expect_words(full_f, 137, 8);
        send_frame(4, full_f, 137, 0, 0, 1'b1, 1'b1);
        chk("popfull_count", o_cnt(4), 32'd4);
        chk("popfull_ovf", o_ovf(4), 32'd0);
        drain(4);

        // Reset after 70 bits
        send_frame(8, full_f, 70, 0, 0, 1'b0, 1'b0);
        chk("midrst_pre_count", o_cnt(8), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dump_en", o_de(8), 32'd0);
        chk("midrst_empty", o_empty(8), 32'd1);
        chk("midrst_count", o_cnt(8), 32'd0);
        chk("midrst_busy", o_busy(8), 32'd0);
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        expect_words(full_f, 137, 8);
        send_frame(8, full_f, 137, 0, 0, 1'b1, 1'b0);
        chk("postrst_count", o_cnt(8), 32'd5);
        chk("postrst_len_err", o_le(8), 32'd0);
        drain(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
